trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences privileged-state transitions for the RV64 M/S CSR file held in a CSRPack.
- Takes synchronous exceptions and pending interrupts at instruction commit, along with mret/sret.
- Selects the target privilege through medeleg/mideleg, drains the pipeline through a flush handshake, and issues one atomic CSRPack update followed by a PC redirect.
- Sits between the commit stage and the CSR register file.

Parameters:
- XLEN, 64, datapath width.
- VEC_EN, 1, when 1, honour vectored mode (tvec[1:0]==1) for interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  instruction retiring this cycle
- commit_pc  in  64  PC of the retiring instruction
- exc_valid  in  1  retiring instruction raised an exception
- exc_cause  in  64  exception code (bit63=0)
- exc_tval  in  64  faulting value
- mret  in  1  retiring instruction is mret
- sret  in  1  retiring instruction is sret
- csr_cur  in  CSRPack  current CSR state, including priv
- flush_ack  in  1  pipeline drained
- flush_req  out  1  request pipeline flush
- csr_we  out  1  write csr_nxt into the CSR file this cycle
- csr_nxt  out  CSRPack  next CSR state; fields not listed below equal csr_cur
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  64  redirect target
- busy  out  1  controller not in IDLE; commit must stall

Behaviour:
- Reset values:
  - FSM state = IDLE.
  - All outputs 0; csr_nxt = csr_cur.
  - Latched event cleared.
  - A reset asserted mid-sequence aborts it; no csr_we is issued afterwards.
- Event capture (IDLE only, when commit_valid=1), in priority order:
  - exc_valid: latch {pc, cause, tval}.
  - Else an eligible interrupt: latch {commit_pc+4, bit63=1|code, tval=0}.
  - Else mret / sret: latch return kind.
  - Commit is blocked while busy, so no events arrive then.
- Interrupt eligibility:
  - pend = mip & mie.
  - Code delegated iff mideleg[code]=1.
  - M-target enabled if priv<M or mstatus.MIE=1.
  - S-target enabled if priv<S or (priv==S and mstatus.SIE=1).
  - Delegated codes are never taken while priv==M.
  - Priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5).
- Exception target: S if priv!=M and medeleg[cause[5:0]]=1; otherwise M.
- FSM:
  - IDLE -> DRAIN when an event is latched.
  - DRAIN: flush_req=1 until flush_ack=1. flush_ack may arrive in the same cycle flush_req rises. -> UPDATE.
  - UPDATE: csr_we=1 for exactly one cycle, with csr_nxt computed from latched data and csr_cur. -> REDIRECT.
  - REDIRECT: redirect_valid=1 for one cycle. -> IDLE.
  - busy=1 in DRAIN, UPDATE and REDIRECT.
  - Minimum latency from event to redirect: 3 cycles (IDLE capture, DRAIN with immediate ack, UPDATE, REDIRECT).
- M trap update:
  - mepc = epc; mcause = cause; mtval = tval.
  - MPIE = MIE; MIE = 0; MPP = priv; priv = 3.
- S trap update:
  - sepc, scause, stval written.
  - SPIE = SIE; SIE = 0; SPP = priv[0]; priv = 1.
  - The sstatus view is mirrored into mstatus bits.
- Trap target PC:
  - tvec & ~3.
  - If VEC_EN, tvec[1:0]==1 and interrupt: base + 4*code, computed modulo 2^64.
- mret:
  - priv = MPP; MIE = MPIE; MPIE = 1; MPP = 0.
  - If MPP != M, MPRV = 0.
  - redirect_pc = mepc.
- sret:
  - priv = {0, SPP}; SIE = SPIE; SPIE = 1; SPP = 0.
  - redirect_pc = sepc.
- Cosim fields:
  - On traps: cosim_epc, cosim_cause and cosim_tval are loaded with the trap values.
  - switch_mode = 1 in the csr_nxt written during UPDATE, 0 otherwise.
  - csr_ret = 1 for mret/sret.
- Boundary conditions:
  - exc_valid together with mret: the exception wins.
  - An interrupt pending in the same cycle as an exception: the exception is taken; the interrupt is re-evaluated at a later commit.
  - csr_cur is sampled in UPDATE, not at capture.

Decomposition:
- Add to CSRStruct package:
  - priv constants PRV_U/S/M;
  - mstatus bit index localparams (SIE=1, MIE=3, SPIE=5, MPIE=7, SPP=8, MPP=12:11, MPRV=17);
  - interrupt code constants;
  - FSM state enum TrapState.
- Sub-module irq_select: combinational priority and eligibility unit producing {valid, code, to_s}.

Test Plan:
- M-mode, illegal instruction (cause 2, tval 0xdead) at pc 0x8000_0100, mtvec=0x8000_0000 -> mepc=0x8000_0100, mcause=2, mtval=0xdead, MPP=3, MIE=0, redirect_pc=0x8000_0000 three cycles later.
- U-mode ecall (cause 8), medeleg[8]=1, stvec=0x8020_0000 -> priv=1, sepc=pc, scause=8, SPP=0, redirect_pc=0x8020_0000; mepc unchanged.
- priv=S, mip=mie=0x80|0x20 (MTI+STI), mideleg=0x20 -> MTI taken to M, mcause=0x8000_0000_0000_0007; with mtvec=0x100|1, redirect_pc=0x11C.
- mret with MPP=1, MPIE=1 -> priv=1, MIE=1, MPIE=1, MPP=0, MPRV=0, redirect_pc=mepc.
- flush_ack withheld 5 cycles -> flush_req held high 5 cycles, csr_we stays 0 until the cycle after ack.
- rst asserted during DRAIN -> next cycle all outputs 0, IDLE, no csr_we ever pulses.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the trap controller and its CSR file view.
// CSRPack is the single bundle exchanged with the CSR register file.
package trap_controller_pkg;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPRV   = 17;

    localparam logic [3:0] IRQ_SSI = 4'd1;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_STI = 4'd5;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_SEI = 4'd9;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_UPDATE,
        ST_REDIRECT
    } TrapState;

    typedef enum logic [1:0] {
        EV_EXC,
        EV_IRQ,
        EV_MRET,
        EV_SRET
    } EventKind;

    typedef struct packed {
        logic [1:0]  priv;
        logic [63:0] mstatus;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mtvec;
        logic [63:0] sepc;
        logic [63:0] scause;
        logic [63:0] stval;
        logic [63:0] stvec;
        logic [63:0] medeleg;
        logic [63:0] mideleg;
        logic [63:0] mip;
        logic [63:0] mie;
        logic [63:0] cosim_epc;
        logic [63:0] cosim_cause;
        logic [63:0] cosim_tval;
        logic        switch_mode;
        logic        csr_ret;
    } CSRPack;

    // Rank 0 is the most urgent interrupt.
    function automatic logic [3:0] irq_prio(input int rank);
        case (rank)
            0:       return IRQ_MEI;
            1:       return IRQ_MSI;
            2:       return IRQ_MTI;
            3:       return IRQ_SEI;
            4:       return IRQ_SSI;
            default: return IRQ_STI;
        endcase
    endfunction

endpackage

// File: rtl/trap_controller_irq_select.sv
// Picks the most urgent pending interrupt that the current privilege
// and enable bits allow, and reports whether it is delegated to S.
module irq_select
    import trap_controller_pkg::*;
(
    input  logic [1:0]  priv,
    input  logic        sie,
    input  logic        mie_en,
    input  logic [11:0] pend,
    input  logic [11:0] deleg,
    output logic        valid,
    output logic [5:0]  code,
    output logic        to_s
);

    logic       m_en;
    logic       s_en;
    logic [3:0] c;

    // A delegated code can never fire in M because s_en is 0 there.
    assign m_en = (priv < PRV_M) || mie_en;
    assign s_en = (priv < PRV_S) || ((priv == PRV_S) && sie);

    always_comb begin
        valid = 1'b0;
        code  = '0;
        to_s  = 1'b0;
        c     = '0;
        for (int i = 0; i < 6; i++) begin
            c = irq_prio(i);
            if (!valid && pend[c] && (deleg[c] ? s_en : m_en)) begin
                valid = 1'b1;
                code  = {2'b00, c};
                to_s  = deleg[c];
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Commit-time trap/return sequencer: capture, drain, one atomic CSR
// update, then a single-cycle fetch redirect.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit VEC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            sret,
    input  CSRPack          csr_cur,
    input  logic            flush_ack,
    output logic            flush_req,
    output logic            csr_we,
    output CSRPack          csr_nxt,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    TrapState        state;
    EventKind        ev_kind;
    logic [XLEN-1:0] ev_epc;
    logic [XLEN-1:0] ev_cause;
    logic [XLEN-1:0] ev_tval;
    logic            ev_irq_s;

    logic            irq_valid;
    logic [5:0]      irq_code;
    logic            irq_to_s;

    logic            to_s;
    logic            vec;
    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] tgt_pc;
    logic [1:0]      mpp;
    CSRPack          nxt;

    irq_select u_irq_select (
        .priv   (csr_cur.priv),
        .sie    (csr_cur.mstatus[MSTATUS_SIE]),
        .mie_en (csr_cur.mstatus[MSTATUS_MIE]),
        .pend   (csr_cur.mip[11:0] & csr_cur.mie[11:0]),
        .deleg  (csr_cur.mideleg[11:0]),
        .valid  (irq_valid),
        .code   (irq_code),
        .to_s   (irq_to_s)
    );

    assign mpp = csr_cur.mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

    // Exception target is resolved against csr_cur as seen in UPDATE.
    assign to_s = (ev_kind == EV_IRQ) ? ev_irq_s :
                  ((csr_cur.priv != PRV_M) &&
                   csr_cur.medeleg[ev_cause[5:0]]);
    assign tvec = to_s ? csr_cur.stvec : csr_cur.mtvec;
    assign vec  = VEC_EN && (ev_kind == EV_IRQ) && (tvec[1:0] == 2'b01);
    assign trap_pc = {tvec[XLEN-1:2], 2'b00} +
                     (vec ? (XLEN'(ev_cause[5:0]) << 2) : '0);

    always_comb begin
        nxt             = csr_cur;
        nxt.switch_mode = 1'b0;
        nxt.csr_ret     = 1'b0;
        tgt_pc          = '0;
        if (state == ST_UPDATE) begin
            nxt.switch_mode = 1'b1;
            unique case (ev_kind)
                EV_MRET: begin
                    nxt.priv = mpp;
                    nxt.mstatus[MSTATUS_MIE]  = csr_cur.mstatus[MSTATUS_MPIE];
                    nxt.mstatus[MSTATUS_MPIE] = 1'b1;
                    nxt.mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_U;
                    if (mpp != PRV_M)
                        nxt.mstatus[MSTATUS_MPRV] = 1'b0;
                    nxt.csr_ret = 1'b1;
                    tgt_pc      = csr_cur.mepc;
                end
                EV_SRET: begin
                    nxt.priv = {1'b0, csr_cur.mstatus[MSTATUS_SPP]};
                    nxt.mstatus[MSTATUS_SIE]  = csr_cur.mstatus[MSTATUS_SPIE];
                    nxt.mstatus[MSTATUS_SPIE] = 1'b1;
                    nxt.mstatus[MSTATUS_SPP]  = 1'b0;
                    nxt.csr_ret = 1'b1;
                    tgt_pc      = csr_cur.sepc;
                end
                default: begin
                    nxt.cosim_epc   = ev_epc;
                    nxt.cosim_cause = ev_cause;
                    nxt.cosim_tval  = ev_tval;
                    tgt_pc          = trap_pc;
                    if (to_s) begin
                        nxt.sepc   = ev_epc;
                        nxt.scause = ev_cause;
                        nxt.stval  = ev_tval;
                        nxt.mstatus[MSTATUS_SPIE] = csr_cur.mstatus[MSTATUS_SIE];
                        nxt.mstatus[MSTATUS_SIE]  = 1'b0;
                        nxt.mstatus[MSTATUS_SPP]  = csr_cur.priv[0];
                        nxt.priv = PRV_S;
                    end else begin
                        nxt.mepc  = ev_epc;
                        nxt.mcause = ev_cause;
                        nxt.mtval = ev_tval;
                        nxt.mstatus[MSTATUS_MPIE] = csr_cur.mstatus[MSTATUS_MIE];
                        nxt.mstatus[MSTATUS_MIE]  = 1'b0;
                        nxt.mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = csr_cur.priv;
                        nxt.priv = PRV_M;
                    end
                end
            endcase
        end
    end

    assign csr_nxt = nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ev_kind        <= EV_EXC;
            ev_epc         <= '0;
            ev_cause       <= '0;
            ev_tval        <= '0;
            ev_irq_s       <= 1'b0;
            flush_req      <= 1'b0;
            csr_we         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            csr_we         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (commit_valid &&
                        (exc_valid || irq_valid || mret || sret)) begin
                        state     <= ST_DRAIN;
                        flush_req <= 1'b1;
                        busy      <= 1'b1;
                        ev_irq_s  <= 1'b0;
                        ev_epc    <= commit_pc;
                        ev_cause  <= '0;
                        ev_tval   <= '0;
                        if (exc_valid) begin
                            ev_kind  <= EV_EXC;
                            ev_cause <= exc_cause;
                            ev_tval  <= exc_tval;
                        end else if (irq_valid) begin
                            ev_kind  <= EV_IRQ;
                            ev_epc   <= commit_pc + XLEN'(4);
                            ev_cause <= {1'b1, {(XLEN-7){1'b0}}, irq_code};
                            ev_irq_s <= irq_to_s;
                        end else if (mret) begin
                            ev_kind <= EV_MRET;
                        end else begin
                            ev_kind <= EV_SRET;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (flush_ack) begin
                        state     <= ST_UPDATE;
                        flush_req <= 1'b0;
                        csr_we    <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= tgt_pc;
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Randomised and directed checks of trap_controller against a
// behavioural model of the privileged trap/return rules.
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        exc_valid;
    logic [63:0] exc_cause;
    logic [63:0] exc_tval;
    logic        mret;
    logic        sret;
    CSRPack      csr_cur;
    logic        flush_ack;
    logic        flush_req;
    logic        csr_we;
    CSRPack      csr_nxt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int we_pulses = 0;

    trap_controller #(.XLEN(64), .VEC_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .mret           (mret),
        .sret           (sret),
        .csr_cur        (csr_cur),
        .flush_ack      (flush_ack),
        .flush_req      (flush_req),
        .csr_we         (csr_we),
        .csr_nxt        (csr_nxt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (csr_we) we_pulses <= we_pulses + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [1:0] rand_priv();
        case ($urandom_range(2))
            0:       return 2'd0;
            1:       return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [63:0] rand_tvec();
        logic [63:0] t;
        t = r64();
        t[1] = 1'b0;
        t[0] = ($urandom_range(1) != 0);
        return t;
    endfunction

    function automatic CSRPack rand_csr();
        CSRPack c;
        c.priv        = rand_priv();
        c.mstatus     = r64();
        c.mstatus[12:11] = rand_priv();
        c.mepc        = r64();
        c.mcause      = r64();
        c.mtval       = r64();
        c.mtvec       = rand_tvec();
        c.sepc        = r64();
        c.scause      = r64();
        c.stval       = r64();
        c.stvec       = rand_tvec();
        c.medeleg     = r64();
        c.mideleg     = 64'($urandom_range(4095));
        c.mip         = 64'($urandom_range(4095));
        c.mie         = 64'($urandom_range(4095));
        c.cosim_epc   = r64();
        c.cosim_cause = r64();
        c.cosim_tval  = r64();
        c.switch_mode = 1'b0;
        c.csr_ret     = 1'b0;
        return c;
    endfunction

    task automatic clear_inputs();
        commit_valid = 1'b0;
        exc_valid    = 1'b0;
        mret         = 1'b0;
        sret         = 1'b0;
        commit_pc    = '0;
        exc_cause    = '0;
        exc_tval     = '0;
    endtask

    // Reference interrupt arbitration straight from the privilege rules.
    task automatic model_irq(input CSRPack c, output int code,
                             output bit to_s);
        int prio [6] = '{11, 3, 7, 9, 1, 5};
        bit ok;
        code = -1;
        to_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int k = prio[i];
            if (code < 0 && c.mip[k] && c.mie[k]) begin
                if (c.mideleg[k])
                    ok = (c.priv == 2'd0) ||
                         (c.priv == 2'd1 && c.mstatus[1]);
                else
                    ok = (c.priv != 2'd3) || c.mstatus[3];
                if (ok) begin
                    code = k;
                    to_s = c.mideleg[k];
                end
            end
        end
    endtask

    // kind: 0 exception, 1 interrupt, 2 mret, 3 sret
    task automatic model_update(input CSRPack c, input int kind,
                                input logic [63:0] epc,
                                input logic [63:0] cause,
                                input logic [63:0] tval, input bit irq_s,
                                output CSRPack n, output logic [63:0] pc);
        bit s_tgt;
        logic [63:0] tv;
        int code;
        n = c;
        n.switch_mode = 1'b1;
        n.csr_ret = 1'b0;
        code = int'(cause[5:0]);
        if (kind == 2) begin
            n.priv = c.mstatus[12:11];
            n.mstatus[3] = c.mstatus[7];
            n.mstatus[7] = 1'b1;
            n.mstatus[12:11] = 2'd0;
            if (c.mstatus[12:11] != 2'd3) n.mstatus[17] = 1'b0;
            n.csr_ret = 1'b1;
            pc = c.mepc;
        end else if (kind == 3) begin
            n.priv = {1'b0, c.mstatus[8]};
            n.mstatus[1] = c.mstatus[5];
            n.mstatus[5] = 1'b1;
            n.mstatus[8] = 1'b0;
            n.csr_ret = 1'b1;
            pc = c.sepc;
        end else begin
            s_tgt = (kind == 1) ? irq_s :
                    (c.priv != 2'd3 && c.medeleg[code]);
            tv = s_tgt ? c.stvec : c.mtvec;
            pc = tv - (tv % 64'd4);
            if (kind == 1 && (tv % 64'd4) == 64'd1)
                pc = pc + 64'd4 * 64'(code);
            n.cosim_epc = epc;
            n.cosim_cause = cause;
            n.cosim_tval = tval;
            if (s_tgt) begin
                n.sepc = epc; n.scause = cause; n.stval = tval;
                n.mstatus[5] = c.mstatus[1];
                n.mstatus[1] = 1'b0;
                n.mstatus[8] = c.priv[0];
                n.priv = 2'd1;
            end else begin
                n.mepc = epc; n.mcause = cause; n.mtval = tval;
                n.mstatus[7] = c.mstatus[3];
                n.mstatus[3] = 1'b0;
                n.mstatus[12:11] = c.priv;
                n.priv = 2'd3;
            end
        end
    endtask

    task automatic check_csr(input CSRPack e);
        check("nxt_priv", 64'(csr_nxt.priv), 64'(e.priv));
        check("nxt_mstatus", csr_nxt.mstatus, e.mstatus);
        check("nxt_mepc", csr_nxt.mepc, e.mepc);
        check("nxt_mcause", csr_nxt.mcause, e.mcause);
        check("nxt_sepc", csr_nxt.sepc, e.sepc);
        check("nxt_scause", csr_nxt.scause, e.scause);
        check("nxt_cosim_cause", csr_nxt.cosim_cause, e.cosim_cause);
        check("nxt_flags", {62'd0, csr_nxt.switch_mode, csr_nxt.csr_ret},
              {62'd0, e.switch_mode, e.csr_ret});
        check("nxt_all", 64'(csr_nxt == e), 64'd1);
    endtask

    // Called at a negedge with the commit inputs already driven.
    task automatic do_event(input int ack_delay, input bit mutate,
                            output CSRPack got_nxt,
                            output logic [63:0] got_pc);
        int kind;
        int code;
        bit irq_s;
        int held;
        logic [63:0] epc, cause, tval, exp_pc;
        CSRPack exp_nxt;
        epc = '0; cause = '0; tval = '0; exp_pc = '0;
        got_nxt = csr_cur;
        got_pc = '0;
        model_irq(csr_cur, code, irq_s);
        if (!commit_valid) kind = -1;
        else if (exc_valid) begin
            kind = 0; epc = commit_pc; cause = exc_cause; tval = exc_tval;
        end else if (code >= 0) begin
            kind = 1; epc = commit_pc + 64'd4;
            cause = 64'h8000_0000_0000_0000 + 64'(code);
        end else if (mret) kind = 2;
        else if (sret) kind = 3;
        else kind = -1;
        @(negedge clk);
        clear_inputs();
        if (kind < 0) begin
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_flush", 64'(flush_req), 64'd0);
            return;
        end
        check("flush_rise", 64'(flush_req), 64'd1);
        check("busy_drain", 64'(busy), 64'd1);
        held = 0;
        repeat (ack_delay) begin
            if (flush_req) held++;
            check("we_drain", 64'(csr_we), 64'd0);
            if (mutate) begin
                csr_cur.mtvec = rand_tvec();
                csr_cur.stvec = rand_tvec();
                csr_cur.mepc  = r64();
                csr_cur.sepc  = r64();
            end
            @(negedge clk);
        end
        check("flush_hold", 64'(held), 64'(ack_delay));
        check("flush_at_ack", 64'(flush_req), 64'd1);
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
        check("we_pulse", 64'(csr_we), 64'd1);
        check("flush_drop", 64'(flush_req), 64'd0);
        model_update(csr_cur, kind, epc, cause, tval, irq_s, exp_nxt, exp_pc);
        got_nxt = csr_nxt;
        check_csr(exp_nxt);
        @(negedge clk);
        check("redir_valid", 64'(redirect_valid), 64'd1);
        check("redir_pc", redirect_pc, exp_pc);
        check("we_once", 64'(csr_we), 64'd0);
        got_pc = redirect_pc;
        csr_cur = exp_nxt;
        csr_cur.switch_mode = 1'b0;
        csr_cur.csr_ret = 1'b0;
        @(negedge clk);
        check("redir_end", 64'(redirect_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        CSRPack g;
        logic [63:0] gp;
        int base;

        rst = 1'b1;
        flush_ack = 1'b0;
        clear_inputs();
        csr_cur = rand_csr();
        repeat (3) @(negedge clk);
        check("rst_flush", 64'(flush_req), 64'd0);
        check("rst_we", 64'(csr_we), 64'd0);
        check("rst_redir", {63'd0, redirect_valid} | redirect_pc, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_nxt", 64'(csr_nxt == csr_cur), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // M-mode illegal instruction, with mret and a live MEI alongside
        csr_cur = rand_csr();
        csr_cur.priv = 2'd3;
        csr_cur.mtvec = 64'h8000_0000;
        csr_cur.mstatus[3] = 1'b1;
        csr_cur.mip = 64'h800;
        csr_cur.mie = 64'h800;
        csr_cur.mideleg = '0;
        commit_valid = 1'b1; commit_pc = 64'h8000_0100;
        exc_valid = 1'b1; exc_cause = 64'd2; exc_tval = 64'hdead;
        mret = 1'b1;
        do_event(0, 1'b0, g, gp);
        check("ill_mepc", g.mepc, 64'h8000_0100);
        check("ill_mcause", g.mcause, 64'd2);
        check("ill_mtval", g.mtval, 64'hdead);
        check("ill_mpp_mie", {g.mstatus[12:11], g.mstatus[3]}, 64'b110);
        check("ill_pc", gp, 64'h8000_0000);

        // U-mode ecall delegated to S
        csr_cur = rand_csr();
        csr_cur.priv = 2'd0;
        csr_cur.medeleg = 64'h100;
        csr_cur.stvec = 64'h8020_0000;
        csr_cur.mepc = 64'h1234;
        csr_cur.mie = '0;
        commit_valid = 1'b1; commit_pc = 64'h40;
        exc_valid = 1'b1; exc_cause = 64'd8; exc_tval = '0;
        do_event(1, 1'b0, g, gp);
        check("ecall_priv", 64'(g.priv), 64'd1);
        check("ecall_sepc", g.sepc, 64'h40);
        check("ecall_scause", g.scause, 64'd8);
        check("ecall_spp", 64'(g.mstatus[8]), 64'd0);
        check("ecall_mepc", g.mepc, 64'h1234);
        check("ecall_pc", gp, 64'h8020_0000);

        // MTI beats delegated STI from S, vectored
        csr_cur = rand_csr();
        csr_cur.priv = 2'd1;
        csr_cur.mstatus = '0;
        csr_cur.mip = 64'ha0;
        csr_cur.mie = 64'ha0;
        csr_cur.mideleg = 64'h20;
        csr_cur.mtvec = 64'h101;
        commit_valid = 1'b1; commit_pc = 64'h4000;
        do_event(0, 1'b0, g, gp);
        check("mti_mcause", g.mcause, 64'h8000_0000_0000_0007);
        check("mti_mepc", g.mepc, 64'h4004);
        check("mti_pc", gp, 64'h11c);

        // mret to S clears MPRV; ack withheld five cycles
        csr_cur = rand_csr();
        csr_cur.mip = '0;
        csr_cur.mstatus[12:11] = 2'd1;
        csr_cur.mstatus[7] = 1'b1;
        csr_cur.mstatus[3] = 1'b0;
        csr_cur.mstatus[17] = 1'b1;
        csr_cur.mepc = 64'h8000_2000;
        commit_valid = 1'b1; mret = 1'b1;
        do_event(5, 1'b0, g, gp);
        check("mret_priv", 64'(g.priv), 64'd1);
        check("mret_bits", {g.mstatus[17], g.mstatus[12:11],
              g.mstatus[7], g.mstatus[3]}, 64'b00011);
        check("mret_pc", gp, 64'h8000_2000);

        // Reset during DRAIN aborts the sequence
        csr_cur = rand_csr();
        commit_valid = 1'b1; commit_pc = r64();
        exc_valid = 1'b1; exc_cause = 64'd5;
        @(negedge clk);
        clear_inputs();
        check("abort_drain", 64'(flush_req), 64'd1);
        base = we_pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", {60'd0, flush_req, csr_we, redirect_valid, busy}
              | redirect_pc, 64'd0);
        check("abort_nxt", 64'(csr_nxt == csr_cur), 64'd1);
        flush_ack = 1'b1;
        repeat (6) @(negedge clk);
        flush_ack = 1'b0;
        check("abort_no_we", 64'(we_pulses - base), 64'd0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1) != 0) csr_cur = rand_csr();
            commit_valid = ($urandom_range(7) != 0);
            commit_pc    = r64();
            exc_valid    = ($urandom_range(2) == 0);
            exc_cause    = 64'($urandom_range(15));
            exc_tval     = r64();
            mret         = ($urandom_range(3) == 0);
            sret         = ($urandom_range(3) == 0);
            do_event($urandom_range(4), ($urandom_range(1) != 0), g, gp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
